// File: rtl/bridge_actuator_seq.sv
// bridge_actuator_seq: turns drawbridge controller requests into timed,
// interlocked barrier/bridge motor and lamp commands with a latched fault.
// Ports:
//   i_clk, i_reset (async, active high)
//   i_bridge_req, i_barrier_req, i_alert_req  requests from controller
//   i_barrier_dn/up, i_bridge_up/dn           limit switches
//   o_bar_mot_dn/up, o_brg_mot_up/dn          motor drives
//   o_lamp, o_road_clear, o_fault             status outputs
module bridge_actuator_seq #(
   parameter int WARN_CYC  = 8,
   parameter int MOTOR_TMO = 64,
   parameter int BLINK_DIV = 4,
   parameter int CNT_W     = 8
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_bridge_req,
   input  logic i_barrier_req,
   input  logic i_alert_req,
   input  logic i_barrier_dn,
   input  logic i_barrier_up,
   input  logic i_bridge_up,
   input  logic i_bridge_dn,
   output logic o_bar_mot_dn,
   output logic o_bar_mot_up,
   output logic o_brg_mot_up,
   output logic o_brg_mot_dn,
   output logic o_lamp,
   output logic o_road_clear,
   output logic o_fault
);

   typedef enum logic [3:0] {
      IDLE,
      WARN,
      BAR_LOWER,
      BAR_HELD,
      BRG_RAISE,
      OPEN,
      BRG_LOWER,
      BAR_RAISE,
      FAULT
   } stateT;

   stateT state;
   stateT nState;

   logic [CNT_W-1:0] timer;
   logic [CNT_W-1:0] nTimer;
   logic blink;
   logic nBlink;
   logic nLamp;
   logic conflict;
   logic barrierLost;
   logic anyReq;
   logic warnDone;
   logic motorTmo;
   logic blinkTick;
   logic curBlinks;
   logic nxtBlinks;

   always_comb begin
      conflict = (i_bridge_up & i_bridge_dn) |
                 (i_barrier_up & i_barrier_dn);
      anyReq   = i_barrier_req | i_bridge_req;
      warnDone = timer == CNT_W'(WARN_CYC - 1);
      motorTmo = timer == CNT_W'(MOTOR_TMO - 1);
      // bridge may only be near motion with the barrier held down
      barrierLost = !i_barrier_dn &&
         (state inside {BAR_HELD, BRG_RAISE, OPEN, BRG_LOWER});

      nState = state;
      if (conflict || barrierLost) begin
         nState = FAULT;
      end else begin
         unique case (state)
            IDLE: begin
               if (anyReq) nState = WARN;
            end
            WARN: begin
               if (!anyReq)       nState = IDLE;
               else if (warnDone) nState = BAR_LOWER;
            end
            BAR_LOWER: begin
               if (i_barrier_dn)  nState = BAR_HELD;
               else if (motorTmo) nState = FAULT;
               else if (!anyReq)  nState = BAR_RAISE;
            end
            BAR_HELD: begin
               if (i_bridge_req)        nState = BRG_RAISE;
               else if (!i_barrier_req) nState = BAR_RAISE;
            end
            BRG_RAISE: begin
               if (i_bridge_up)        nState = OPEN;
               else if (motorTmo)      nState = FAULT;
               else if (!i_bridge_req) nState = BRG_LOWER;
            end
            OPEN: begin
               if (!i_bridge_req) nState = BRG_LOWER;
            end
            // lowering always completes; no raise mid-travel
            BRG_LOWER: begin
               if (i_bridge_dn)   nState = BAR_HELD;
               else if (motorTmo) nState = FAULT;
            end
            BAR_RAISE: begin
               if (i_barrier_up)  nState = IDLE;
               else if (motorTmo) nState = FAULT;
            end
            FAULT:   nState = FAULT;
            default: nState = FAULT;
         endcase
      end

      nTimer = (nState != state) ? '0 : timer + CNT_W'(1);

      curBlinks = (state inside {WARN, BAR_LOWER, BAR_RAISE}) ||
                  (state == IDLE && i_alert_req);
      nxtBlinks = (nState inside {WARN, BAR_LOWER, BAR_RAISE}) ||
                  (nState == IDLE && i_alert_req);
      blinkTick = (timer % CNT_W'(BLINK_DIV)) ==
                  CNT_W'(BLINK_DIV - 1);
      // phase restarts from dark whenever blinking was not active
      nBlink = curBlinks & (blink ^ blinkTick);
      nLamp  = nxtBlinks ? nBlink : (nState != IDLE);
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state        <= IDLE;
         timer        <= '0;
         blink        <= 1'b0;
         o_bar_mot_dn <= 1'b0;
         o_bar_mot_up <= 1'b0;
         o_brg_mot_up <= 1'b0;
         o_brg_mot_dn <= 1'b0;
         o_lamp       <= 1'b0;
         o_road_clear <= 1'b0;
         o_fault      <= 1'b0;
      end else begin
         state        <= nState;
         timer        <= nTimer;
         blink        <= nBlink;
         o_bar_mot_dn <= nState == BAR_LOWER;
         o_bar_mot_up <= nState == BAR_RAISE;
         o_brg_mot_up <= nState == BRG_RAISE;
         o_brg_mot_dn <= nState == BRG_LOWER;
         o_lamp       <= nLamp;
         o_road_clear <= nState == IDLE;
         o_fault      <= nState == FAULT;
      end
   end

endmodule

// File: tb/tb_bridge_actuator_seq.sv
// tb_bridge_actuator_seq: scoreboard bench with a behavioural sequencer
// model and a simple limit-switch plant driven by the expected motors.
module tb_bridge_actuator_seq;

   localparam int WARN_CYC  = 8;
   localparam int MOTOR_TMO = 64;
   localparam int BLINK_DIV = 4;
   localparam int CNT_W     = 8;
   localparam int TRAVEL    = 5;

   localparam int IDLE_M  = 0;
   localparam int WARN_M  = 1;
   localparam int BLOW_M  = 2;
   localparam int HELD_M  = 3;
   localparam int RAISE_M = 4;
   localparam int OPEN_M  = 5;
   localparam int LOWER_M = 6;
   localparam int BUP_M   = 7;
   localparam int FAULT_M = 8;

   logic i_clk = 1'b0;
   logic i_reset = 1'b1;
   logic i_bridge_req = 1'b0;
   logic i_barrier_req = 1'b0;
   logic i_alert_req = 1'b0;
   logic i_barrier_dn = 1'b0;
   logic i_barrier_up = 1'b1;
   logic i_bridge_up = 1'b0;
   logic i_bridge_dn = 1'b1;
   logic o_bar_mot_dn;
   logic o_bar_mot_up;
   logic o_brg_mot_up;
   logic o_brg_mot_dn;
   logic o_lamp;
   logic o_road_clear;
   logic o_fault;

   bridge_actuator_seq #(
      .WARN_CYC (WARN_CYC),
      .MOTOR_TMO(MOTOR_TMO),
      .BLINK_DIV(BLINK_DIV),
      .CNT_W    (CNT_W)
   ) dut (
      .i_clk        (i_clk),
      .i_reset      (i_reset),
      .i_bridge_req (i_bridge_req),
      .i_barrier_req(i_barrier_req),
      .i_alert_req  (i_alert_req),
      .i_barrier_dn (i_barrier_dn),
      .i_barrier_up (i_barrier_up),
      .i_bridge_up  (i_bridge_up),
      .i_bridge_dn  (i_bridge_dn),
      .o_bar_mot_dn (o_bar_mot_dn),
      .o_bar_mot_up (o_bar_mot_up),
      .o_brg_mot_up (o_brg_mot_up),
      .o_brg_mot_dn (o_brg_mot_dn),
      .o_lamp       (o_lamp),
      .o_road_clear (o_road_clear),
      .o_fault      (o_fault)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int passes = 0;

   // {fault, roadClear, lamp, brgDn, brgUp, barUp, barDn}
   logic [6:0] sb[$];

   int mMode = IDLE_M;
   int mAge = 0;
   bit mBlink = 1'b0;

   int barPos = 0;
   int brgPos = 0;
   bit dropBar = 1'b0;
   bit stuckUp = 1'b0;
   bit barConf = 1'b0;
   bit brgConf = 1'b0;

   function automatic bit blinks(input int m, input bit alert);
      return (m inside {WARN_M, BLOW_M, BUP_M}) ||
             (m == IDLE_M && alert);
   endfunction

   function automatic int doneOf(input int m);
      case (m)
         BLOW_M:  return HELD_M;
         RAISE_M: return OPEN_M;
         LOWER_M: return HELD_M;
         default: return IDLE_M;
      endcase
   endfunction

   task automatic modelReset();
      mMode = IDLE_M;
      mAge = 0;
      mBlink = 1'b0;
   endtask

   task automatic modelStep(output logic [6:0] e);
      int nm;
      bit nb;
      bit lamp;
      bit reached;
      bit anyReq;
      bit inMotor;
      anyReq = i_barrier_req || i_bridge_req;
      inMotor = mMode inside {BLOW_M, RAISE_M, LOWER_M, BUP_M};
      case (mMode)
         BLOW_M:  reached = i_barrier_dn;
         RAISE_M: reached = i_bridge_up;
         LOWER_M: reached = i_bridge_dn;
         BUP_M:   reached = i_barrier_up;
         default: reached = 1'b0;
      endcase
      nm = mMode;
      if ((i_bridge_up && i_bridge_dn) ||
          (i_barrier_up && i_barrier_dn))
         nm = FAULT_M;
      else if ((mMode inside {HELD_M, RAISE_M, OPEN_M, LOWER_M})
               && !i_barrier_dn)
         nm = FAULT_M;
      else if (inMotor && reached)
         nm = doneOf(mMode);
      else if (inMotor && mAge == MOTOR_TMO - 1)
         nm = FAULT_M;
      else begin
         case (mMode)
            IDLE_M: if (anyReq) nm = WARN_M;
            WARN_M: begin
               if (!anyReq) nm = IDLE_M;
               else if (mAge == WARN_CYC - 1) nm = BLOW_M;
            end
            BLOW_M: if (!anyReq) nm = BUP_M;
            HELD_M: begin
               if (i_bridge_req) nm = RAISE_M;
               else if (!i_barrier_req) nm = BUP_M;
            end
            RAISE_M: if (!i_bridge_req) nm = LOWER_M;
            OPEN_M:  if (!i_bridge_req) nm = LOWER_M;
            default: ;
         endcase
      end
      if (blinks(mMode, i_alert_req))
         nb = (mAge % BLINK_DIV == BLINK_DIV - 1) ? !mBlink : mBlink;
      else
         nb = 1'b0;
      if (nm inside {HELD_M, RAISE_M, OPEN_M, LOWER_M, FAULT_M})
         lamp = 1'b1;
      else if (blinks(nm, i_alert_req))
         lamp = nb;
      else
         lamp = 1'b0;
      mAge = (nm == mMode) ? (mAge + 1) % (1 << CNT_W) : 0;
      mMode = nm;
      mBlink = nb;
      e = {nm == FAULT_M, nm == IDLE_M, lamp, nm == LOWER_M,
           nm == RAISE_M, nm == BUP_M, nm == BLOW_M};
   endtask

   task automatic setSw();
      i_barrier_dn = ((barPos == TRAVEL) && !dropBar) || barConf;
      i_barrier_up = (barPos == 0) || barConf;
      i_bridge_up  = ((brgPos == TRAVEL) && !stuckUp) || brgConf;
      i_bridge_dn  = (brgPos == 0) || brgConf;
   endtask

   task automatic tick();
      logic [6:0] e;
      @(posedge i_clk);
      if (i_reset) begin
         modelReset();
         e = '0;
      end else begin
         modelStep(e);
      end
      sb.push_back(e);
      if (e[0] && barPos < TRAVEL) barPos++;
      if (e[1] && barPos > 0) barPos--;
      if (e[2] && brgPos < TRAVEL) brgPos++;
      if (e[3] && brgPos > 0) brgPos--;
      #1;
      setSw();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Called just after an edge: outputs clear at once, so the
   // pending expectation for this cycle becomes the reset state.
   task automatic assertReset();
      i_reset = 1'b1;
      if (sb.size() > 0) void'(sb.pop_back());
      sb.push_back('0);
      modelReset();
      i_bridge_req = 1'b0;
      i_barrier_req = 1'b0;
      barPos = 0;
      brgPos = 0;
      dropBar = 1'b0;
      stuckUp = 1'b0;
      barConf = 1'b0;
      brgConf = 1'b0;
      setSw();
      ticks(2);
      i_reset = 1'b0;
   endtask

   task automatic waitMode(input int m, input int maxCyc);
      int n;
      n = 0;
      while (mMode != m && n < maxCyc) begin
         tick();
         n++;
      end
      checks++;
      if (mMode == m) passes++;
      else $display("FAIL waitMode: mode %0d want %0d after %0d cyc",
                    mMode, m, n);
   endtask

   always @(negedge i_clk) begin
      logic [6:0] act;
      logic [6:0] e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         act = {o_fault, o_road_clear, o_lamp, o_brg_mot_dn,
                o_brg_mot_up, o_bar_mot_up, o_bar_mot_dn};
         checks++;
         if (act === e) passes++;
         else $display("FAIL outputs @%0t: got %b want %b",
                       $time, act, e);
         checks++;
         if ((o_bar_mot_dn & o_bar_mot_up) |
             (o_brg_mot_up & o_brg_mot_dn) |
             ((o_bar_mot_dn | o_bar_mot_up) &
              (o_brg_mot_up | o_brg_mot_dn)))
            $display("FAIL interlock @%0t: motors %b%b%b%b",
                     $time, o_bar_mot_dn, o_bar_mot_up,
                     o_brg_mot_up, o_brg_mot_dn);
         else passes++;
      end
   end

   initial begin
      int r;
      modelReset();
      setSw();
      ticks(3);
      i_reset = 1'b0;
      ticks(3);

      // full open / close sequence
      i_barrier_req = 1'b1;
      i_bridge_req = 1'b1;
      waitMode(OPEN_M, 100);
      ticks(4);
      i_bridge_req = 1'b0;
      waitMode(HELD_M, 100);
      ticks(2);
      i_barrier_req = 1'b0;
      waitMode(IDLE_M, 100);
      ticks(3);

      // abort at cycle 3 of bridge raise
      i_barrier_req = 1'b1;
      i_bridge_req = 1'b1;
      waitMode(RAISE_M, 100);
      ticks(3);
      i_bridge_req = 1'b0;
      waitMode(HELD_M, 100);
      i_barrier_req = 1'b0;
      waitMode(IDLE_M, 100);

      // reset mid bridge raise
      i_barrier_req = 1'b1;
      i_bridge_req = 1'b1;
      waitMode(RAISE_M, 100);
      ticks(2);
      assertReset();
      ticks(3);

      // bridge-up switch stuck: timeout, fault latched
      stuckUp = 1'b1;
      i_barrier_req = 1'b1;
      i_bridge_req = 1'b1;
      waitMode(FAULT_M, 300);
      i_barrier_req = 1'b0;
      i_bridge_req = 1'b0;
      ticks(10);
      assertReset();
      ticks(2);

      // bridge switch conflict in IDLE
      brgConf = 1'b1;
      setSw();
      tick();
      brgConf = 1'b0;
      setSw();
      ticks(4);
      assertReset();
      ticks(2);

      // barrier-down switch drops while open
      i_alert_req = 1'b1;
      i_barrier_req = 1'b1;
      i_bridge_req = 1'b1;
      waitMode(OPEN_M, 100);
      dropBar = 1'b1;
      setSw();
      tick();
      dropBar = 1'b0;
      setSw();
      ticks(3);
      assertReset();
      ticks(6);

      for (int it = 0; it < 300; it++) begin
         r = $urandom_range(99);
         if (mMode == FAULT_M) begin
            ticks(2);
            assertReset();
         end else if (r < 3) begin
            if ($urandom_range(1)) brgConf = 1'b1;
            else barConf = 1'b1;
            setSw();
            tick();
            brgConf = 1'b0;
            barConf = 1'b0;
            setSw();
         end else if (r < 6) begin
            dropBar = 1'b1;
            setSw();
            tick();
            dropBar = 1'b0;
            setSw();
         end else if (r < 8) begin
            assertReset();
         end else begin
            i_barrier_req = 1'($urandom_range(1));
            i_bridge_req = 1'($urandom_range(3) != 0);
            i_alert_req = 1'($urandom_range(1));
            ticks($urandom_range(1, 30));
         end
      end

      i_barrier_req = 1'b0;
      i_bridge_req = 1'b0;
      ticks(2);
      @(negedge i_clk);
      #1;
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
